tt_um_pwm_top: RTL and testbench

TT_UM_PWM_TOP -- requirements
Module: tt_um_pwm_top

---
 rtl/tt_um_pwm_top.sv | 92 +++++++++
 tb/tb_tt_um_pwm_top.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/tt_um_pwm_top.sv
// ---------------------------------------------------------------------------
// tt_um_pwm_top
// 8-bit PWM generator with a 3-bit power-of-two prescaler, a duty shadow
// register reloaded once per period, and a period-start pulse.
//
// Ports
//   clk      in   system clock, all state changes on the rising edge
//   rst_n    in   synchronous reset, ACTIVE-HIGH despite the name
//   ena      in   design enable (0 holds prescaler, counter and duty)
//   ui_in    in   [7:0] requested duty D, sampled only at period wrap
//   uio_in   in   [2:0] prescaler select P, [3] invert, [4] run
//   uo_out   out  [0] PWM, [1] complementary PWM, [2] period-start pulse,
//                 [7:3] cnt[7:3]
//   uio_out  out  constant 0
//   uio_oe   out  constant 0 (all uio pins are inputs)
//
// Build option
//   PWM_COMPL_EN  defined: uo_out[1] = ~uo_out[0]; undefined: uo_out[1] = 0
// ---------------------------------------------------------------------------
module tt_um_pwm_top (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    logic [7:0] pc;
    logic [7:0] cnt;
    logic [7:0] dsh;
    logic       pulse;

    logic       active;
    logic [7:0] pc_max;
    logic       tick;
    logic       wrap;
    logic       pwm;
    logic       pwm_c;
    logic       unused_bits;

    assign active = ena & uio_in[4];

    // 2^P - 1 as a low-order mask; equality (not >=) lets a prescaler that
    // is already past the new limit run on through 255 -> 0 before ticking.
    assign pc_max = ~(8'hFF << uio_in[2:0]);
    assign tick   = active & (pc == pc_max);
    assign wrap   = tick & (cnt == 8'hFF);

    always_ff @(posedge clk) begin
        if (rst_n) begin
            pc    <= '0;
            cnt   <= '0;
            dsh   <= '0;
            pulse <= 1'b0;
        end else begin
            pulse <= wrap;
            if (active) begin
                pc <= tick ? '0 : pc + 8'd1;
                if (tick) begin
                    cnt <= cnt + 8'd1;
                end
                if (wrap) begin
                    dsh <= ui_in;
                end
            end
        end
    end

    assign pwm = (cnt < dsh) ^ uio_in[3];

`ifdef PWM_COMPL_EN
    assign pwm_c = ~pwm;
`else
    assign pwm_c = 1'b0;
`endif

    always_comb begin
        uo_out      = '0;
        uo_out[0]   = pwm;
        uo_out[1]   = pwm_c;
        uo_out[2]   = pulse;
        uo_out[7:3] = cnt[7:3];
    end

    assign uio_out     = '0;
    assign uio_oe      = '0;
    assign unused_bits = &{1'b0, uio_in[7:5]};

endmodule

// File: tb/tb_tt_um_pwm_top.sv
module tb_tt_um_pwm_top;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    tt_um_pwm_top dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state: plain integers stepped by the rules of the block.
    int m_pc;
    int m_cnt;
    int m_dsh;
    int m_pulse;

    logic [7:0] exp_q[$];
    int vectors;
    int miscompares;
    int pushed;
    int cyc;

    // Apply one rising edge to the model with the inputs that edge sees.
    task automatic model_edge(input bit rst, input bit en, input bit run,
                              input int d, input int p);
        bit tk;
        tk = 1'b0;
        if (rst) begin
            m_pc = 0; m_cnt = 0; m_dsh = 0; m_pulse = 0;
        end else begin
            m_pulse = 0;
            if (en && run) begin
                if (m_pc == (1 << p) - 1) begin
                    tk = 1'b1;
                    m_pc = 0;
                end else begin
                    m_pc = (m_pc + 1) % 256;
                end
                if (tk) begin
                    if (m_cnt == 255) begin
                        m_cnt = 0;
                        m_dsh = d;
                        m_pulse = 1;
                    end else begin
                        m_cnt = m_cnt + 1;
                    end
                end
            end
        end
    endtask

    function automatic logic [7:0] model_out(input bit inv);
        int pwm;
        int pwm_c;
        pwm = ((m_cnt < m_dsh) ? 1 : 0) ^ (inv ? 1 : 0);
`ifdef PWM_COMPL_EN
        pwm_c = 1 - pwm;
`else
        pwm_c = 0;
`endif
        return 8'(((m_cnt / 8) * 8) + (m_pulse * 4) + (pwm_c * 2) + pwm);
    endfunction

    // d < 0 means a fresh random duty every clock (must have no effect
    // except at the wrap edge).
    task automatic drive(input int n, input bit rst, input bit en, input bit run,
                         input int d, input int p, input bit inv);
        int dv;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            dv = (d < 0) ? int'($urandom_range(0, 255)) : d;
            rst_n  = rst;
            ena    = en;
            ui_in  = 8'(dv);
            uio_in = {3'($urandom), run, inv, 3'(p)};
            model_edge(rst, en, run, dv, p);
            exp_q.push_back(model_out(inv));
            pushed++;
        end
    endtask

    // Monitor: samples just after every rising edge, pops one expectation.
    always @(posedge clk) begin
        logic [7:0] e;
        #1;
        cyc++;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            vectors++;
            if (uo_out !== e) begin
                miscompares++;
                $display("FAIL uo_out cyc=%0d got=%02h exp=%02h", cyc, uo_out, e);
            end
            if (uio_out !== 8'h00 || uio_oe !== 8'h00) begin
                miscompares++;
                $display("FAIL uio_const cyc=%0d got out=%02h oe=%02h exp=00/00",
                         cyc, uio_out, uio_oe);
            end
        end
    end

    initial begin
        int d;
        vectors = 0; miscompares = 0; pushed = 0; cyc = 0;
        m_pc = 0; m_cnt = 0; m_dsh = 0; m_pulse = 0;
        rst_n = 1'b1; ena = 1'b0; ui_in = '0; uio_in = '0;

        // Reset, with inversion on and off.
        drive(3, 1'b1, 1'b0, 1'b0, -1, 0, 1'b0);
        drive(2, 1'b1, 1'b1, 1'b1, -1, 0, 1'b1);
        // D=64, P=0: first period low, then 64 high / 192 low.
        drive(256 * 3, 1'b0, 1'b1, 1'b1, 64, 0, 1'b0);
        // D changed 64 -> 200 mid-period: effective only from next wrap.
        drive(100, 1'b0, 1'b1, 1'b1, 64, 0, 1'b0);
        drive(156 + 512, 1'b0, 1'b1, 1'b1, 200, 0, 1'b0);
        // D=0 then D=255 loaded at wraps.
        drive(512, 1'b0, 1'b1, 1'b1, 0, 0, 1'b0);
        drive(512, 1'b0, 1'b1, 1'b1, 255, 0, 1'b0);
        // Freeze mid-period via ena, then via run; random duty while frozen.
        drive(100, 1'b0, 1'b1, 1'b1, 100, 0, 1'b0);
        drive(100, 1'b0, 1'b0, 1'b1, -1, 0, 1'b0);
        drive(100, 1'b0, 1'b1, 1'b0, -1, 0, 1'b0);
        drive(300, 1'b0, 1'b1, 1'b1, 100, 0, 1'b0);
        // Inversion.
        drive(512, 1'b0, 1'b1, 1'b1, 90, 0, 1'b1);
        // P=3, D=128: 2048-clk periods.
        drive(2048 * 2 + 100, 1'b0, 1'b1, 1'b1, 128, 3, 1'b0);
        // P drop mid-count: prescaler past the new limit wraps through 255.
        drive(5, 1'b0, 1'b1, 1'b1, 128, 3, 1'b0);
        drive(600, 1'b0, 1'b1, 1'b1, 128, 1, 1'b0);
        drive(300, 1'b0, 1'b1, 1'b1, -1, 7, 1'b1);
        // Reset mid-period, then first period runs with dsh=0.
        drive(300, 1'b0, 1'b1, 1'b1, 64, 0, 1'b0);
        drive(2, 1'b1, 1'b1, 1'b1, 64, 0, 1'b0);
        drive(600, 1'b0, 1'b1, 1'b1, 64, 0, 1'b1);
        drive(2, 1'b1, 1'b1, 1'b1, 64, 0, 1'b1);
        drive(300, 1'b0, 1'b1, 1'b1, 30, 0, 1'b0);
        // Randomised segments.
        for (int s = 0; s < 25; s++) begin
            d = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, 255));
            drive(int'($urandom_range(1, 300)),
                  ($urandom_range(0, 19) == 0),
                  ($urandom_range(0, 7) != 0),
                  ($urandom_range(0, 7) != 0),
                  d, int'($urandom_range(0, 2)), 1'($urandom));
        end

        @(negedge clk);
        @(negedge clk);
        if (exp_q.size() != 0 || vectors != pushed) begin
            miscompares++;
            $display("FAIL drain got=%0d checked exp=%0d", vectors, pushed);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
